// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered, zero-skew
// sync and blanking decode, a vertical-blank frame tick and a frame counter.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  output logic       hsync,
  output logic       vsync,
  output logic       display_on,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       frame_tick,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // Boundaries sized to the counter width so every compare is 10 bits wide.
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS_END    = 10'(V_DISPLAY);
  localparam logic [9:0] H_SYNC_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] H_SYNC_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] V_SYNC_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [9:0] hpos_q, hpos_d;
  logic [9:0] vpos_q, vpos_d;
  logic [7:0] frame_count_q, frame_count_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       display_on_q, display_on_d;
  logic       h_last, v_last;

  // Next-state counters and decode of the position the counters move to.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned, which would otherwise infer a latch.
    hpos_d        = hpos_q;
    vpos_d        = vpos_q;
    frame_count_d = frame_count_q;
    // ">=" keeps the counters bounded even if they ever start out of range.
    h_last        = (hpos_q >= H_LAST);
    v_last        = (vpos_q >= V_LAST);

    if (ena) begin
      if (h_last) begin
        hpos_d = '0;
        if (v_last) begin
          vpos_d        = '0;
          frame_count_d = frame_count_q + 8'd1;
        end else begin
          vpos_d = vpos_q + 10'd1;
        end
      end else begin
        hpos_d = hpos_q + 10'd1;
      end
    end

    // Decoding the *next* position and registering it makes the registered
    // sync/blank flags line up with the counters in the same cycle.
    hsync_d      = !((hpos_d >= H_SYNC_START) && (hpos_d < H_SYNC_END));
    vsync_d      = !((vpos_d >= V_SYNC_START) && (vpos_d < V_SYNC_END));
    display_on_d = (hpos_d < H_VIS_END) && (vpos_d < V_VIS_END);
  end

  // State register; reset wins over ena and returns to the top-left pixel.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      hpos_q        <= '0;
      vpos_q        <= '0;
      frame_count_q <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      display_on_q  <= 1'b1;
    end else begin
      hpos_q        <= hpos_d;
      vpos_q        <= vpos_d;
      frame_count_q <= frame_count_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      display_on_q  <= display_on_d;
    end
  end

  assign hpos        = hpos_q;
  assign vpos        = vpos_q;
  assign frame_count = frame_count_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign display_on  = display_on_q;
  // Qualified by ena so a frozen generator never emits a tick.
  assign frame_tick  = ena && (hpos_q == '0) && (vpos_q == V_VIS_END);

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: a default-timing instance (A) for line-level checks and a
// shrunken-timing instance (B) so whole frames fit in a short run.
// B timing: H 8+2+3+2 = 15 (hsync low at hpos 10..12),
//           V 6+1+2+1 = 10 (vsync low at vpos 7..8), 150 clocks per frame.
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, ena_a, hsync_a, vsync_a, disp_a, tick_a;
  logic [9:0] hpos_a, vpos_a;
  logic [7:0] fc_a;
  logic       rst_b, ena_b, hsync_b, vsync_b, disp_b, tick_b;
  logic [9:0] hpos_b, vpos_b;
  logic [7:0] fc_b;

  vga_sync_gen u_dut_a (
    .clk(clk), .rst(rst_a), .ena(ena_a),
    .hsync(hsync_a), .vsync(vsync_a), .display_on(disp_a),
    .hpos(hpos_a), .vpos(vpos_a), .frame_tick(tick_a), .frame_count(fc_a)
  );

  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) u_dut_b (
    .clk(clk), .rst(rst_b), .ena(ena_b),
    .hsync(hsync_b), .vsync(vsync_b), .display_on(disp_b),
    .hpos(hpos_b), .vpos(vpos_b), .frame_tick(tick_b), .frame_count(fc_b)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state for instance B.
  int mh, mv, mfc;
  int n_ticks_b;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick_clk();
    @(posedge clk);
    #1;
  endtask

  // One clock of instance B with the given ena, checked against the model.
  task automatic step_b(input logic e);
    logic exp_tick;
    ena_b = e;
    #1;
    exp_tick = e && (mh == 0) && (mv == 6);
    check("b_frame_tick", tick_b, exp_tick);
    if (tick_b === 1'b1) n_ticks_b++;
    @(posedge clk);
    #1;
    if (e) begin
      if (mh == 14) begin
        mh = 0;
        if (mv == 9) begin
          mv  = 0;
          mfc = (mfc + 1) % 256;
        end else begin
          mv++;
        end
      end else begin
        mh++;
      end
    end
    check("b_hpos",  hpos_b, mh);
    check("b_vpos",  vpos_b, mv);
    check("b_fc",    fc_b,   mfc);
    check("b_hsync", hsync_b, !(mh >= 10 && mh < 13));
    check("b_vsync", vsync_b, !(mv >= 7 && mv < 9));
    check("b_disp",  disp_b,  (mh < 8) && (mv < 6));
  endtask

  initial begin
    int eh, ev, hs_low, first_low, v_changes;
    int vs_low_b, disp_cnt_b;
    logic [9:0] prev_v;

    rst_a = 1'b1; ena_a = 1'b1;
    rst_b = 1'b1; ena_b = 1'b1;
    mh = 0; mv = 0; mfc = 0; n_ticks_b = 0;

    // ---- A: reset state ----
    tick_clk();
    rst_a = 1'b0;
    #1;
    check("a_rst_hpos",  hpos_a, 0);
    check("a_rst_vpos",  vpos_a, 0);
    check("a_rst_fc",    fc_a,   0);
    check("a_rst_hsync", hsync_a, 1);
    check("a_rst_vsync", vsync_a, 1);
    check("a_rst_disp",  disp_a,  1);
    check("a_rst_tick",  tick_a,  0);

    // ---- A: one full line, hpos 1..799 then 0, vpos 0 -> 1 once ----
    hs_low = 0; first_low = -1; v_changes = 0; prev_v = vpos_a;
    for (int i = 1; i <= 800; i++) begin
      tick_clk();
      eh = i % 800;
      ev = i / 800;
      check("a_hpos",  hpos_a, eh);
      check("a_vpos",  vpos_a, ev);
      check("a_hsync", hsync_a, !(eh >= 656 && eh < 752));
      check("a_disp",  disp_a,  (eh < 640) && (ev < 480));
      if (hsync_a === 1'b0) begin
        if (first_low < 0) first_low = int'(hpos_a);
        hs_low++;
      end
      if (vpos_a !== prev_v) v_changes++;
      prev_v = vpos_a;
    end
    check("a_hsync_low_cycles", hs_low, 96);
    check("a_hsync_first_low",  first_low, 656);
    check("a_vpos_changes",     v_changes, 1);
    check("a_vsync_line",       vsync_a, 1);
    check("a_fc_line",          fc_a, 0);

    // ---- A: reset mid-line inside the hsync pulse ----
    repeat (700) tick_clk();
    check("a_pre_rst_hpos",  hpos_a, 700);
    check("a_pre_rst_vpos",  vpos_a, 1);
    check("a_pre_rst_hsync", hsync_a, 0);
    check("a_pre_rst_disp",  disp_a,  0);
    rst_a = 1'b1;
    tick_clk();
    check("a_mid_rst_hpos",  hpos_a, 0);
    check("a_mid_rst_vpos",  vpos_a, 0);
    check("a_mid_rst_fc",    fc_a,   0);
    check("a_mid_rst_hsync", hsync_a, 1);
    check("a_mid_rst_vsync", vsync_a, 1);
    check("a_mid_rst_disp",  disp_a,  1);
    rst_a = 1'b0;
    tick_clk();
    check("a_post_rst_hpos", hpos_a, 1);
    check("a_post_rst_vpos", vpos_a, 0);

    // ---- B: 256 frames with ena held high ----
    rst_b = 1'b0;
    vs_low_b = 0; disp_cnt_b = 0;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 150; k++) begin
        if (f == 0) begin
          if (vsync_b === 1'b0) vs_low_b++;
          if (disp_b === 1'b1) disp_cnt_b++;
        end
        step_b(1'b1);
      end
      if (f == 0) begin
        check("b_frame1_fc",   fc_b, 1);
        check("b_frame1_hpos", hpos_b, 0);
        check("b_frame1_vpos", vpos_b, 0);
        check("b_frame1_vsync_low", vs_low_b, 30);
        check("b_frame1_disp_cycles", disp_cnt_b, 48);
        check("b_frame1_ticks", n_ticks_b, 1);
      end
    end
    check("b_256_fc",    fc_b, 0);
    check("b_256_ticks", n_ticks_b, 256);

    // ---- B: freeze at the last pixel of the frame, then resume ----
    repeat (149) step_b(1'b1);
    check("b_last_hpos", hpos_b, 14);
    check("b_last_vpos", vpos_b, 9);
    repeat (5) step_b(1'b0);
    step_b(1'b1);
    check("b_resume_hpos", hpos_b, 0);
    check("b_resume_vpos", vpos_b, 0);
    check("b_resume_fc",   fc_b,   1);

    // ---- B: random ena over roughly two frames ----
    for (int i = 0; i < 400; i++) step_b(logic'($urandom_range(0, 3) != 0));

    // ---- B: reset mid-frame with both syncs low ----
    for (int i = 0; i < 200 && !(mh == 11 && mv == 7); i++) step_b(1'b1);
    check("b_pre_rst_hsync", hsync_b, 0);
    check("b_pre_rst_vsync", vsync_b, 0);
    check("b_pre_rst_disp",  disp_b,  0);
    rst_b = 1'b1; ena_b = 1'b1;
    tick_clk();
    mh = 0; mv = 0; mfc = 0;
    check("b_mid_rst_hpos",  hpos_b, 0);
    check("b_mid_rst_vpos",  vpos_b, 0);
    check("b_mid_rst_fc",    fc_b,   0);
    check("b_mid_rst_hsync", hsync_b, 1);
    check("b_mid_rst_vsync", vsync_b, 1);
    check("b_mid_rst_disp",  disp_b,  1);
    rst_b = 1'b0;
    step_b(1'b1);
    check("b_post_rst_hpos", hpos_b, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 Parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 Parameter H_FRONT, default 16, horizontal front porch clocks.
REQ-003 Parameter H_SYNC, default 96, horizontal sync pulse clocks.
REQ-004 Parameter H_BACK, default 48, horizontal back porch clocks.
REQ-005 Parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 Parameter V_FRONT, default 10, vertical front porch lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync pulse lines.
REQ-008 Parameter V_BACK, default 33, vertical back porch lines.
REQ-009 clk  input  1  pixel clock; all state updates on rising edge.
REQ-010 rst  input  1  reset, synchronous and active-high.
REQ-011 ena  input  1  count enable; 0 freezes all state.
REQ-012 hsync  output  1  horizontal sync, active-low.
REQ-013 vsync  output  1  vertical sync, active-low.
REQ-014 display_on  output  1  high when the current pixel is visible.
REQ-015 hpos  output  10  current pixel column, 0..H_TOTAL-1.
REQ-016 vpos  output  10  current line, 0..V_TOTAL-1.
REQ-017 frame_tick  output  1  one-cycle pulse on the first cycle of vertical blank.
REQ-018 frame_count  output  8  frames completed since reset, mod 256.

Function
REQ-019 H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
REQ-020 With ena=1, hpos increments by 1 each clock; at hpos=H_TOTAL-1 it wraps to 0 on the next clock.
REQ-021 vpos increments by 1 only on the clock where hpos wraps; at vpos=V_TOTAL-1 with hpos wrapping, vpos wraps to 0.
REQ-022 hsync = 0 exactly when H_DISPLAY+H_FRONT <= hpos < H_DISPLAY+H_FRONT+H_SYNC (656..751), else 1.
REQ-023 vsync = 0 exactly when V_DISPLAY+V_FRONT <= vpos < V_DISPLAY+V_FRONT+V_SYNC (490..491), else 1.
REQ-024 display_on = 1 exactly when hpos < H_DISPLAY and vpos < V_DISPLAY.
REQ-025 hsync, vsync, display_on shall be registered (glitch-free) yet aligned with the hpos/vpos presented in the same cycle: zero cycles of skew.
REQ-026 frame_tick = 1 exactly in the cycle where hpos=0 and vpos=V_DISPLAY, and ena=1; 0 otherwise.
REQ-027 frame_count increments by 1 on the clock edge where vpos wraps V_TOTAL-1 -> 0; wraps 255 -> 0.
REQ-028 With ena=0: hpos, vpos, frame_count, hsync, vsync, display_on hold; frame_tick = 0.
REQ-029 ena toggling shall not skip or repeat any (hpos,vpos) pair; sequence resumes from the held value.
REQ-030 Counters shall never exceed H_TOTAL-1 / V_TOTAL-1 under any ena pattern.

Reset
REQ-031 rst=1 at a rising edge sets hpos=0, vpos=0, frame_count=0, hsync=1, vsync=1, display_on=1, frame_tick=0.
REQ-032 rst has priority over ena; reset mid-line or mid-frame takes effect on the next edge with no residual state.
REQ-033 First clock after rst deasserts (ena=1) yields hpos=1, vpos=0.

Verification
REQ-034 Reset then ena=1 for 800 clocks -> hpos sequences 0..799 then 0, vpos goes 0->1 exactly once; hsync low for exactly 96 cycles starting at hpos=656.
REQ-035 Run 420000 clocks (one frame) from reset -> vsync low for exactly 1600 cycles (vpos 490..491); display_on high for exactly 307200 cycles; frame_count=1 at hpos=0,vpos=0; frame_tick seen once at vpos=480,hpos=0.
REQ-036 Run 256 frames -> frame_count returns to 0; frame_tick pulses 256 times, each one cycle wide.
REQ-037 Drop ena for 5 clocks at hpos=799,vpos=524 -> all outputs hold; on re-enable next values hpos=0, vpos=0, frame_count incremented once.
REQ-038 Assert rst for 1 clock at hpos=300,vpos=200 -> next cycle hpos=0, vpos=0, frame_count=0, hsync=1, vsync=1, display_on=1.
REQ-039 Random ena pattern over 2 frames -> compare hpos/vpos/sync/display_on against reference model every cycle; zero mismatches.
